// File: rtl/nios_dbg_ocimem_ctrl.sv
// -----------------------------------------------------------------------------
// nios_dbg_ocimem_ctrl
//
// Debug-side on-chip memory controller for the Nios II debug slave. JTAG
// read/write commands arriving as take_* strobes plus the jdo word are
// executed against a single-port 2^ADDR_W x 32 debug RAM. The CPU reaches
// the same RAM through an Avalon-MM slave port. JTAG always has priority
// over the CPU.
//
// Optional feature macro: NIOS_DBG_OCIMEM_WP_EN
//   When defined, JTAG writes to word addresses >= WP_BASE are suppressed
//   and flag monitor_error. CPU writes are never protected.
//
// Ports
//   clk                      system clock
//   reset_n                  asynchronous active-low reset
//   jdo[37:0]                JTAG data word ([17:10] addr, [25] error clear,
//                            [34] read request, [34:3] write data)
//   take_action_ocimem_a     load address / optional read / error clear
//   take_no_action_ocimem_a  read at the monitor address, post-increment
//   take_action_ocimem_b     write at the monitor address, post-increment
//   avs_address              CPU word address
//   avs_read / avs_write     CPU read / write requests
//   avs_writedata            CPU write data
//   avs_byteenable           CPU byte enables
//   avs_readdata             CPU read data (valid when waitrequest is low)
//   avs_waitrequest          stall to the CPU (combinational)
//   MonDReg                  last JTAG read data
//   monitor_ready            last JTAG command has completed
//   monitor_error            sticky error flag
// -----------------------------------------------------------------------------
module nios_dbg_ocimem_ctrl #(
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] WP_BASE = 8'hF0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

`ifdef NIOS_DBG_OCIMEM_WP_EN
    localparam logic WP_EN = 1'b1;
`else
    localparam logic WP_EN = 1'b0;
`endif

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CPU_RD  = 2'd1,
        ST_JTAG_RD = 2'd2,
        ST_JTAG_WR = 2'd3
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   mon_a_r;
    logic                pend_valid_r;
    logic                pend_wr_r;
    logic [31:0]         pend_data_r;
    logic [31:0]         mon_d_r;
    logic                ready_r;
    logic                error_r;
    logic [31:0]         ram_q_r;
    logic [31:0]         mem [0:DEPTH-1];

    logic                any_strobe_s;
    logic                multi_strobe_s;
    logic                hon_a_s;
    logic                queue_s;
    logic                accept_s;
    logic                jtag_issue_s;
    logic                wp_hit_s;
    logic                wp_drop_s;
    logic                cpu_we_s;
    logic                cpu_re_s;
    logic                ram_we_s;
    logic                ram_re_s;
    logic                err_set_s;
    logic                err_clr_s;
    logic [ADDR_W-1:0]   ram_addr_s;
    logic [31:0]         ram_wdata_s;
    logic [3:0]          ram_be_s;
    logic                unused_jdo_s;

    // jdo bits outside the decoded fields carry nothing for this block
    assign unused_jdo_s = ^{jdo[37:35], jdo[2:0]};

    assign wp_hit_s = WP_EN && (mon_a_r >= WP_BASE);

    // Strobe decode, pending-command arbitration and RAM port steering
    always_comb begin
        any_strobe_s   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
        multi_strobe_s = (take_action_ocimem_a & take_no_action_ocimem_a) |
                         (take_action_ocimem_a & take_action_ocimem_b) |
                         (take_no_action_ocimem_a & take_action_ocimem_b);
        // action_b outranks action_a, which outranks no_action_a
        hon_a_s        = take_action_ocimem_a & ~take_action_ocimem_b;
        queue_s        = take_action_ocimem_b |
                         (hon_a_s & jdo[34]) |
                         (take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b);
        // only one command may be outstanding; later strobes are dropped
        accept_s       = any_strobe_s & ~pend_valid_r;

        jtag_issue_s   = (state_r == ST_IDLE) & pend_valid_r;
        wp_drop_s      = jtag_issue_s & pend_wr_r & wp_hit_s;
        cpu_we_s       = reset_n & (state_r == ST_IDLE) & ~pend_valid_r & avs_write;
        cpu_re_s       = (state_r == ST_IDLE) & ~pend_valid_r & avs_read & ~avs_write;
        ram_we_s       = (jtag_issue_s & pend_wr_r & ~wp_hit_s) | cpu_we_s;
        ram_re_s       = (jtag_issue_s & ~pend_wr_r) | cpu_re_s;

        err_set_s      = multi_strobe_s | (any_strobe_s & pend_valid_r) | wp_drop_s;
        err_clr_s      = accept_s & hon_a_s & jdo[25];

        if (jtag_issue_s) begin
            ram_addr_s  = mon_a_r;
            ram_wdata_s = pend_data_r;
            ram_be_s    = 4'hF;
        end else begin
            ram_addr_s  = avs_address;
            ram_wdata_s = avs_writedata;
            ram_be_s    = avs_byteenable;
        end
    end

    // Stall the CPU except when its access completes this cycle
    assign avs_waitrequest = ~(reset_n &
                               (((state_r == ST_CPU_RD) & avs_read) |
                                ((state_r == ST_IDLE) & avs_write & ~pend_valid_r)));

    // RAM array write port (contents are intentionally not reset)
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we_s && ram_be_s[i]) begin
                mem[ram_addr_s][8*i +: 8] <= ram_wdata_s[8*i +: 8];
            end
        end
    end

    // Synchronous RAM read register, shared by JTAG and CPU reads
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ram_q_r <= 32'h0000_0000;
        end else if (ram_re_s) begin
            ram_q_r <= mem[ram_addr_s];
        end else begin
            ram_q_r <= ram_q_r;
        end
    end

    // Main FSM together with the JTAG monitor registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            mon_a_r      <= {ADDR_W{1'b0}};
            pend_valid_r <= 1'b0;
            pend_wr_r    <= 1'b0;
            pend_data_r  <= 32'h0000_0000;
            mon_d_r      <= 32'h0000_0000;
            ready_r      <= 1'b0;
            error_r      <= 1'b0;
        end else begin
            // an address load from action_a wins over the post-increment
            if (hon_a_s) begin
                mon_a_r <= jdo[10 +: ADDR_W];
            end else if (state_r == ST_JTAG_RD || state_r == ST_JTAG_WR) begin
                mon_a_r <= mon_a_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                mon_a_r <= mon_a_r;
            end

            // setting the error outranks clearing it in the same cycle
            if (err_set_s) begin
                error_r <= 1'b1;
            end else if (err_clr_s) begin
                error_r <= 1'b0;
            end else begin
                error_r <= error_r;
            end

            if (accept_s) begin
                ready_r <= 1'b0;
            end

            if (accept_s && queue_s) begin
                pend_valid_r <= 1'b1;
                pend_wr_r    <= take_action_ocimem_b;
                pend_data_r  <= jdo[34:3];
            end

            case (state_r)
                ST_IDLE: begin
                    if (pend_valid_r) begin
                        state_r <= pend_wr_r ? ST_JTAG_WR : ST_JTAG_RD;
                    end else if (cpu_re_s) begin
                        state_r <= ST_CPU_RD;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CPU_RD: begin
                    state_r <= ST_IDLE;
                end
                ST_JTAG_RD: begin
                    mon_d_r      <= ram_q_r;
                    ready_r      <= 1'b1;
                    pend_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                ST_JTAG_WR: begin
                    ready_r      <= 1'b1;
                    pend_valid_r <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign avs_readdata  = ram_q_r;
    assign MonDReg       = mon_d_r;
    assign monitor_ready = ready_r;
    assign monitor_error = error_r;

endmodule

// File: tb/tb_nios_dbg_ocimem_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for nios_dbg_ocimem_ctrl. A behavioural model (word array,
// monitor address, sticky error) predicts every observed value; stimulus is
// randomized with $urandom. Honours NIOS_DBG_OCIMEM_WP_EN like the design.
// -----------------------------------------------------------------------------
module tb_nios_dbg_ocimem_ctrl;

`ifdef NIOS_DBG_OCIMEM_WP_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif
    localparam logic [7:0] WP_BASE = 8'hF0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        act_a, nact_a, act_b;
    logic [7:0]  avs_address;
    logic        avs_read, avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;

    int n_vec = 0;
    int n_bad = 0;

    // reference model
    logic [31:0] m_mem [256];
    logic [7:0]  m_addr;
    logic        m_err;

    nios_dbg_ocimem_ctrl dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (act_a),
        .take_no_action_ocimem_a (nact_a),
        .take_action_ocimem_b    (act_b),
        .avs_address             (avs_address),
        .avs_read                (avs_read),
        .avs_write               (avs_write),
        .avs_writedata           (avs_writedata),
        .avs_byteenable          (avs_byteenable),
        .avs_readdata            (avs_readdata),
        .avs_waitrequest         (avs_waitrequest),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j = {6'($urandom), 32'($urandom)};
        j[17:10] = a;
        j[25]    = clr;
        j[34]    = rd;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    // model of a JTAG write at the current monitor address
    function automatic void model_jtag_write(input logic [31:0] d);
        if (WP_ON && m_addr >= WP_BASE) m_err = 1'b1;
        else m_mem[m_addr] = d;
        m_addr = m_addr + 8'd1;
    endfunction

    task automatic pulse(input logic a, input logic na, input logic b, input logic [37:0] j);
        jdo = j; act_a = a; nact_a = na; act_b = b;
        step();
        act_a = 1'b0; nact_a = 1'b0; act_b = 1'b0;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
        #1;
        n_vec++;
        if (avs_waitrequest !== 1'b0) begin
            n_bad++;
            $display("FAIL cpu_write_wait: got %b want 0 (addr %h)", avs_waitrequest, a);
        end
        step();
        avs_write = 1'b0;
        for (int i = 0; i < 4; i++)
            if (be[i]) m_mem[a][8*i +: 8] = d[8*i +: 8];
    endtask

    // bounded CPU read; waits = cycles with waitrequest high before completion
    task automatic cpu_read(input logic [7:0] a, output logic [31:0] d, output int waits, output bit got);
        avs_address = a; avs_read = 1'b1;
        waits = 0; got = 1'b0; d = 32'h0;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (avs_waitrequest === 1'b0) begin
                d = avs_readdata;
                got = 1'b1;
            end else begin
                waits++;
            end
            step();
        end
        avs_read = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; jdo = '0; act_a = 0; nact_a = 0; act_b = 0;
        avs_address = 8'h00; avs_read = 1'b0; avs_write = 1'b1;
        avs_writedata = 32'h0; avs_byteenable = 4'hF;
        step(); step();
        n_vec++; if (MonDReg !== 32'h0) begin n_bad++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
        n_vec++; if (monitor_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", monitor_ready); end
        n_vec++; if (monitor_error !== 1'b0) begin n_bad++; $display("FAIL rst_error: got %b want 0", monitor_error); end
        n_vec++; if (avs_readdata !== 32'h0) begin n_bad++; $display("FAIL rst_readdata: got %h want 0", avs_readdata); end
        n_vec++; if (avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL rst_wait: got %b want 1", avs_waitrequest); end
        avs_write = 1'b0;
        reset_n = 1'b1;
        step();
        m_addr = 8'h00; m_err = 1'b0;
        // give every word a known value
        for (int a = 0; a < 256; a++) cpu_write(8'(a), $urandom, 4'hF);
    endtask

    task automatic test_jtag_read();
        cpu_write(8'h10, 32'hDEADBEEF, 4'hF);
        cpu_write(8'h11, $urandom, 4'hF);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'h10, 1'b1, 1'b0));
        m_addr = 8'h11;
        n_vec++; if (monitor_ready !== 1'b0) begin n_bad++; $display("FAIL rd_ready_low: got %b want 0", monitor_ready); end
        step();
        n_vec++; if (monitor_ready !== 1'b0) begin n_bad++; $display("FAIL rd_ready_early: got %b want 0", monitor_ready); end
        step();
        n_vec++; if (MonDReg !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", MonDReg); end
        n_vec++; if (monitor_ready !== 1'b1) begin n_bad++; $display("FAIL rd_ready: got %b want 1", monitor_ready); end
        // post-increment: the next no_action read must come from 0x11
        pulse(1'b0, 1'b1, 1'b0, jdo_a(8'h00, 1'b0, 1'b0));
        step(); step();
        n_vec++; if (MonDReg !== m_mem[8'h11]) begin n_bad++; $display("FAIL rd_incr: got %h want %h", MonDReg, m_mem[8'h11]); end
        m_addr = 8'h12;
    endtask

    task automatic test_wrap();
        logic [31:0] d; int w; bit g;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'hFE, 1'b0, 1'b1));
        m_addr = 8'hFE; m_err = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            pulse(1'b0, 1'b0, 1'b1, jdo_b(32'(k)));
            step(); step();
            model_jtag_write(32'(k));
            n_vec++; if (monitor_ready !== 1'b1) begin n_bad++; $display("FAIL wrap_ready: got %b want 1 (k=%0d)", monitor_ready, k); end
        end
        n_vec++; if (monitor_error !== m_err) begin n_bad++; $display("FAIL wrap_error: got %b want %b", monitor_error, m_err); end
        for (int k = 0; k < 3; k++) begin
            logic [7:0] a;
            a = 8'hFE + 8'(k);
            cpu_read(a, d, w, g);
            n_vec++; if (!g || d !== m_mem[a]) begin n_bad++; $display("FAIL wrap_read: got %h want %h (addr %h done %0d)", d, m_mem[a], a, g); end
        end
    endtask

    task automatic test_contention();
        logic [31:0] d; int w; bit g;
        logic [7:0] a, b;
        a = 8'($urandom); b = 8'($urandom);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(a, 1'b1, 1'b0));
        m_addr = a + 8'd1;
        cpu_read(b, d, w, g);
        n_vec++; if (w !== 3) begin n_bad++; $display("FAIL cont_wait: got %0d want 3", w); end
        n_vec++; if (!g || d !== m_mem[b]) begin n_bad++; $display("FAIL cont_data: got %h want %h", d, m_mem[b]); end
        n_vec++; if (MonDReg !== m_mem[a]) begin n_bad++; $display("FAIL cont_jtag: got %h want %h", MonDReg, m_mem[a]); end
        cpu_read(b, d, w, g);
        n_vec++; if (w !== 1) begin n_bad++; $display("FAIL uncont_wait: got %0d want 1", w); end
    endtask

    task automatic test_pending_error();
        logic [7:0] a, x; logic [31:0] d; int w; bit g;
        a = 8'($urandom); x = 8'($urandom); d = $urandom;
        pulse(1'b1, 1'b0, 1'b0, jdo_a(a, 1'b1, 1'b1));
        pulse(1'b0, 1'b1, 1'b0, jdo_a(8'h00, 1'b0, 1'b0));  // dropped
        step();
        m_addr = a + 8'd1; m_err = 1'b1;
        n_vec++; if (monitor_error !== 1'b1) begin n_bad++; $display("FAIL pend_err: got %b want 1", monitor_error); end
        n_vec++; if (MonDReg !== m_mem[a]) begin n_bad++; $display("FAIL pend_data: got %h want %h", MonDReg, m_mem[a]); end
        pulse(1'b1, 1'b0, 1'b0, jdo_a(x, 1'b1, 1'b1));
        m_err = 1'b0;
        n_vec++; if (monitor_error !== 1'b0) begin n_bad++; $display("FAIL err_clear: got %b want 0", monitor_error); end
        step(); step();
        m_addr = x + 8'd1;
        n_vec++; if (MonDReg !== m_mem[x]) begin n_bad++; $display("FAIL clr_read: got %h want %h", MonDReg, m_mem[x]); end
        // two strobes at once: action_b wins, error flagged
        pulse(1'b0, 1'b1, 1'b1, jdo_b(d));
        step(); step();
        a = m_addr;
        model_jtag_write(d);
        m_err = 1'b1;
        n_vec++; if (monitor_error !== 1'b1) begin n_bad++; $display("FAIL multi_err: got %b want 1", monitor_error); end
        cpu_read(a, d, w, g);
        n_vec++; if (!g || d !== m_mem[a]) begin n_bad++; $display("FAIL multi_wr: got %h want %h", d, m_mem[a]); end
    endtask

    task automatic test_write_protect();
        logic [31:0] v, d; int w; bit g;
        v = $urandom; d = ~v;
        cpu_write(8'hF4, v, 4'hF);
        pulse(1'b1, 1'b0, 1'b0, jdo_a(8'hF4, 1'b0, 1'b1));
        m_addr = 8'hF4; m_err = 1'b0;
        pulse(1'b0, 1'b0, 1'b1, jdo_b(d));
        step(); step();
        model_jtag_write(d);
        n_vec++; if (monitor_ready !== 1'b1) begin n_bad++; $display("FAIL wp_ready: got %b want 1", monitor_ready); end
        n_vec++; if (monitor_error !== m_err) begin n_bad++; $display("FAIL wp_error: got %b want %b", monitor_error, m_err); end
        cpu_read(8'hF4, d, w, g);
        n_vec++; if (!g || d !== m_mem[8'hF4]) begin n_bad++; $display("FAIL wp_ram: got %h want %h", d, m_mem[8'hF4]); end
    endtask

    task automatic test_random();
        logic [31:0] d; int w; bit g; logic [7:0] a; logic c;
        for (int it = 0; it < 200; it++) begin
            a = 8'($urandom); d = $urandom; c = 1'($urandom);
            case ($urandom_range(0, 4))
                0: cpu_write(a, d, 4'($urandom));
                1: begin
                    logic [31:0] q;
                    cpu_read(a, q, w, g);
                    n_vec++; if (!g || q !== m_mem[a] || w !== 1) begin n_bad++; $display("FAIL rnd_cpu_rd: got %h want %h (addr %h waits %0d)", q, m_mem[a], a, w); end
                end
                2: begin
                    pulse(1'b1, 1'b0, 1'b0, jdo_a(a, 1'b0, c));
                    m_addr = a; if (c) m_err = 1'b0;
                    pulse(1'b0, 1'b0, 1'b1, jdo_b(d));
                    step(); step();
                    model_jtag_write(d);
                    n_vec++; if (monitor_ready !== 1'b1 || monitor_error !== m_err) begin n_bad++; $display("FAIL rnd_jtag_wr: ready %b err %b want 1 %b", monitor_ready, monitor_error, m_err); end
                end
                3: begin
                    pulse(1'b1, 1'b0, 1'b0, jdo_a(a, 1'b1, c));
                    m_addr = a + 8'd1; if (c) m_err = 1'b0;
                    step(); step();
                    n_vec++; if (MonDReg !== m_mem[a] || monitor_ready !== 1'b1 || monitor_error !== m_err) begin n_bad++; $display("FAIL rnd_jtag_rd: got %h rdy %b err %b want %h 1 %b", MonDReg, monitor_ready, monitor_error, m_mem[a], m_err); end
                end
                default: begin
                    pulse(1'b0, 1'b1, 1'b0, jdo_a(a, 1'b0, 1'b0));
                    step(); step();
                    n_vec++; if (MonDReg !== m_mem[m_addr] || monitor_ready !== 1'b1) begin n_bad++; $display("FAIL rnd_noact_rd: got %h rdy %b want %h 1", MonDReg, monitor_ready, m_mem[m_addr]); end
                    m_addr = m_addr + 8'd1;
                end
            endcase
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int w; bit g;
        pulse(1'b0, 1'b1, 1'b0, jdo_a(8'h00, 1'b0, 1'b0));
        step();  // now in JTAG_RD
        reset_n = 1'b0;
        #1;
        n_vec++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin n_bad++; $display("FAIL mid_rst_out: got %h %b %b want 0 0 0", MonDReg, monitor_ready, monitor_error); end
        n_vec++; if (avs_readdata !== 32'h0 || avs_waitrequest !== 1'b1) begin n_bad++; $display("FAIL mid_rst_avs: got %h %b want 0 1", avs_readdata, avs_waitrequest); end
        step(); step();
        reset_n = 1'b1;
        step();
        m_addr = 8'h00; m_err = 1'b0;
        n_vec++; if (monitor_ready !== 1'b0) begin n_bad++; $display("FAIL post_rst_ready: got %b want 0", monitor_ready); end
        cpu_read(8'h33, d, w, g);
        n_vec++; if (!g || w !== 1 || d !== m_mem[8'h33]) begin n_bad++; $display("FAIL post_rst_idle: got %h waits %0d want %h 1", d, w, m_mem[8'h33]); end
        pulse(1'b0, 1'b1, 1'b0, jdo_a(8'h00, 1'b0, 1'b0));
        step(); step();
        n_vec++; if (MonDReg !== m_mem[8'h00]) begin n_bad++; $display("FAIL post_rst_addr: got %h want %h", MonDReg, m_mem[8'h00]); end
    endtask

    initial begin
        test_reset();
        test_jtag_read();
        test_wrap();
        test_contention();
        test_pending_error();
        test_write_protect();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
